// File: rtl/delay_tap_controller_pkg.sv
// Shared definitions for the runtime-programmable delay tap controller:
// controller state encoding, default geometry and the tap legality check.
package delay_tap_controller_pkg;

   // Default geometry: 15 physical stages, 4-bit tap fields, tap 3 after reset.
   localparam int MAX_TAP_DEFAULT     = 15;
   localparam int TAP_W_DEFAULT       = 4;
   localparam int DEFAULT_TAP_DEFAULT = 3;

   // FILL: a lengthened chain is refilling and the output is gated off.
   // RUN:  the chain holds cur_tap valid samples and requests are accepted.
   typedef enum logic {
      FILL = 1'b0,
      RUN  = 1'b1
   } ctrl_state_t;

   // A tap is usable only if it selects an existing stage (1..max_tap).
   function automatic logic tap_is_illegal(input int unsigned tap,
                                           input int unsigned max_tap);
      return (tap == 0) || (tap > max_tap);
   endfunction

endpackage

// File: rtl/delay_chain_en.sv
// 1-bit DFF delay chain with a per-stage enable. Enabled stages shift data
// towards higher indices; disabled stages are held at zero so unused upper
// stages do not toggle.
module delay_chain_en #(
   parameter int STAGES = 15
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in,
   input  logic [STAGES-1:0] en,
   output logic [STAGES-1:0] taps
);

   genvar k;
   generate
      for (k = 0; k < STAGES; k++) begin : g_stage
         logic q;
         logic d;

         if (k == 0) begin : g_first
            assign d = in;
         end else begin : g_rest
            assign d = taps[k-1];
         end

         // One flop per stage: shift when enabled, otherwise sit cleared.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               q <= 1'b0;
            end else if (en[k]) begin
               q <= d;
            end else begin
               q <= 1'b0;
            end
         end

         assign taps[k] = q;
      end
   endgenerate

endmodule

// File: rtl/delay_tap_controller.sv
// Runtime-configurable delay line controller. Owns the active tap, the
// FILL/RUN sequencing that hides a lengthened chain while it refills, the
// ready/valid configuration handshake and the gated output tap select.
module delay_tap_controller
   import delay_tap_controller_pkg::*;
#(
   parameter int MAX_TAP     = MAX_TAP_DEFAULT,
   parameter int TAP_W       = TAP_W_DEFAULT,
   parameter int DEFAULT_TAP = DEFAULT_TAP_DEFAULT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in,
   input  logic             cfg_valid,
   input  logic [TAP_W-1:0] cfg_tap,
   output logic             cfg_ready,
   output logic             cfg_err,
   output logic             delayed,
   output logic             delayed_valid,
   output logic             busy
);

   ctrl_state_t        state;
   logic [TAP_W-1:0]   cur_tap;
   logic [TAP_W-1:0]   fill_tgt;
   logic [TAP_W-1:0]   fill_cnt;
   logic [MAX_TAP-1:0] stage_en;
   logic [MAX_TAP-1:0] taps;
   logic               tap_bit;
   logic               accept;
   logic               req_illegal;

   assign accept      = cfg_valid && (state == RUN);
   assign req_illegal = tap_is_illegal(32'(cfg_tap), 32'(MAX_TAP));

   // Only stages below the active tap shift; everything above is cleared.
   always_comb begin
      stage_en = '0;
      for (int k = 0; k < MAX_TAP; k++) begin
         stage_en[k] = (TAP_W'(k) < cur_tap);
      end
   end

   delay_chain_en #(
      .STAGES (MAX_TAP)
   ) u_chain (
      .clk   (clk),
      .rst_n (rst_n),
      .in    (in),
      .en    (stage_en),
      .taps  (taps)
   );

   // Controller: refill counting in FILL, request evaluation in RUN. A grow
   // waits exactly N-O edges so the new top stage holds real data on exit;
   // a shrink takes effect at once because lower stages are already valid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= FILL;
         cur_tap  <= TAP_W'(DEFAULT_TAP);
         fill_tgt <= TAP_W'(DEFAULT_TAP);
         fill_cnt <= '0;
         cfg_err  <= 1'b0;
      end else begin
         cfg_err <= 1'b0;
         case (state)
            FILL: begin
               fill_cnt <= fill_cnt + TAP_W'(1);
               if (fill_cnt == fill_tgt - TAP_W'(1)) begin
                  state <= RUN;
               end
            end
            RUN: begin
               if (accept) begin
                  if (req_illegal) begin
                     cfg_err <= 1'b1;
                  end else if (cfg_tap > cur_tap) begin
                     cur_tap  <= cfg_tap;
                     fill_tgt <= cfg_tap - cur_tap;
                     fill_cnt <= '0;
                     state    <= FILL;
                  end else begin
                     cur_tap <= cfg_tap;
                  end
               end
            end
            default: begin
               state <= FILL;
            end
         endcase
      end
   end

   // Select the stage that is cur_tap edges behind the input.
   always_comb begin
      tap_bit = 1'b0;
      for (int k = 0; k < MAX_TAP; k++) begin
         if (cur_tap == TAP_W'(k + 1)) begin
            tap_bit = taps[k];
         end
      end
   end

   assign cfg_ready     = (state == RUN);
   assign delayed_valid = (state == RUN);
   assign busy          = (state == FILL);
   assign delayed       = (state == RUN) ? tap_bit : 1'b0;

endmodule

// File: tb/tb_delay_tap_controller.sv
// Self-checking bench for delay_tap_controller. A behavioural model keeps the
// full input history and the edge at which the output becomes valid, and
// derives every expected output from those with plain arithmetic.
module tb_delay_tap_controller;

   localparam int MAX_TAP     = 15;
   localparam int TAP_W       = 5;
   localparam int DEFAULT_TAP = 3;

   logic             clk;
   logic             rst_n;
   logic             in;
   logic             cfg_valid;
   logic [TAP_W-1:0] cfg_tap;
   logic             cfg_ready;
   logic             cfg_err;
   logic             delayed;
   logic             delayed_valid;
   logic             busy;

   int compared   = 0;
   int mismatched = 0;

   // Reference model state
   logic hist [0:4095];
   int   edge_n;
   int   m_tap;
   int   valid_from;
   logic err_exp;

   delay_tap_controller #(
      .MAX_TAP     (MAX_TAP),
      .TAP_W       (TAP_W),
      .DEFAULT_TAP (DEFAULT_TAP)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .in            (in),
      .cfg_valid     (cfg_valid),
      .cfg_tap       (cfg_tap),
      .cfg_ready     (cfg_ready),
      .cfg_err       (cfg_err),
      .delayed       (delayed),
      .delayed_valid (delayed_valid),
      .busy          (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_bit(input string tag, input logic obs, input logic exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("[TB] FAIL %s: observed=%b expected=%b t=%0t", tag, obs, exp, $time);
      end
   endtask

   task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      edge_n     = 0;
      m_tap      = DEFAULT_TAP;
      valid_from = DEFAULT_TAP;
      err_exp    = 1'b0;
   endtask

   // One clock edge as seen by the model: record the input, then evaluate a
   // request only if the output was already valid before this edge.
   task automatic model_edge(input logic din, input logic v, input logic [TAP_W-1:0] t);
      logic ready_before;
      int   n;
      ready_before = (edge_n >= valid_from);
      edge_n++;
      hist[edge_n] = din;
      err_exp = 1'b0;
      n = int'(t);
      if (ready_before && v) begin
         if (n == 0 || n > MAX_TAP) begin
            err_exp = 1'b1;
         end else if (n > m_tap) begin
            valid_from = edge_n + (n - m_tap);
            m_tap      = n;
         end else begin
            m_tap = n;
         end
      end
   endtask

   task automatic check_output();
      logic exp_valid;
      logic exp_del;
      exp_valid = (edge_n >= valid_from);
      exp_del   = exp_valid ? hist[edge_n - m_tap + 1] : 1'b0;
      check_bit("delayed_valid", delayed_valid, exp_valid);
      check_bit("busy", busy, !exp_valid);
      check_bit("cfg_ready", cfg_ready, exp_valid);
      check_bit("delayed", delayed, exp_del);
      check_bit("cfg_err", cfg_err, err_exp);
   endtask

   task automatic apply_stimulus(input logic din, input logic v, input logic [TAP_W-1:0] t);
      in        = din;
      cfg_valid = v;
      cfg_tap   = t;
      @(posedge clk);
      model_edge(din, v, t);
      #1;
      check_output();
   endtask

   task automatic do_reset();
      cfg_valid = 1'b0;
      cfg_tap   = '0;
      #1 rst_n = 1'b0;
      model_reset();
      #1;
      check_output();
      check_vec("reset_chain", 32'(dut.taps), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      check_output();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n     = 1'b0;
      in        = 1'b1;
      cfg_valid = 1'b0;
      cfg_tap   = '0;
      model_reset();

      // Reset release with in held high: 3 invalid cycles then delayed=1
      $display("[TB] reset release");
      do_reset();
      repeat (6) apply_stimulus(1'b1, 1'b0, '0);

      // Grow 3 -> 7, then a single pulse through the longer chain
      $display("[TB] grow 3 to 7");
      apply_stimulus(1'b0, 1'b1, 5'd7);
      repeat (4) apply_stimulus(1'b0, 1'b0, '0);
      apply_stimulus(1'b1, 1'b0, '0);
      repeat (9) apply_stimulus(1'b0, 1'b0, '0);

      // Shrink 7 -> 2, pulse, upper stages must clear
      $display("[TB] shrink 7 to 2");
      apply_stimulus(1'b1, 1'b1, 5'd2);
      apply_stimulus(1'b0, 1'b0, '0);
      apply_stimulus(1'b1, 1'b0, '0);
      repeat (5) apply_stimulus(1'b0, 1'b0, '0);
      check_vec("upper_stages_clear", 32'(dut.taps[14:2]), 32'd0);

      // Illegal taps 0, 16, 31 (isolated and back to back)
      $display("[TB] illegal taps");
      apply_stimulus(1'b1, 1'b1, 5'd0);
      repeat (3) apply_stimulus(1'($urandom_range(0, 1)), 1'b0, '0);
      apply_stimulus(1'b0, 1'b1, 5'd16);
      apply_stimulus(1'b1, 1'b1, 5'd31);
      repeat (3) apply_stimulus(1'($urandom_range(0, 1)), 1'b0, '0);

      // Grow 2 -> 5 while a held request waits through FILL
      $display("[TB] request held during fill");
      apply_stimulus(1'b1, 1'b1, 5'd5);
      repeat (3) apply_stimulus(1'($urandom_range(0, 1)), 1'b1, 5'd3);
      repeat (4) apply_stimulus(1'($urandom_range(0, 1)), 1'b0, '0);

      // Back-to-back shrinks and a same-tap request
      $display("[TB] back to back requests");
      apply_stimulus(1'b1, 1'b1, 5'd15);
      repeat (12) apply_stimulus(1'($urandom_range(0, 1)), 1'b0, '0);
      apply_stimulus(1'b1, 1'b1, 5'd9);
      apply_stimulus(1'b0, 1'b1, 5'd9);
      apply_stimulus(1'b1, 1'b1, 5'd4);
      apply_stimulus(1'b1, 1'b1, 5'd6);
      repeat (4) apply_stimulus(1'($urandom_range(0, 1)), 1'b0, '0);

      // Reset mid-FILL: 2 of 4 fill cycles done with a request pending
      $display("[TB] reset during fill");
      apply_stimulus(1'b1, 1'b1, 5'd3);
      apply_stimulus(1'b1, 1'b1, 5'd7);
      repeat (2) apply_stimulus(1'b1, 1'b1, 5'd9);
      do_reset();
      repeat (8) apply_stimulus(1'($urandom_range(0, 1)), 1'b0, '0);

      // Randomized traffic
      $display("[TB] random traffic");
      for (int i = 0; i < 400; i++) begin
         apply_stimulus(1'($urandom_range(0, 1)),
                        ($urandom_range(0, 5) == 0),
                        5'($urandom_range(0, 20)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
